// File: rtl/prio_encoder16_if.sv
// Request/grant bundle between a request source/consumer and the 16-to-4 priority encoder.
interface prio_encoder16_if;
    logic        EN;
    logic [15:0] D;
    logic        ACK;
    logic [3:0]  Y;
    logic        V;
    logic [15:0] PEND;

    // Encoder side
    modport slave (
        input  EN, D, ACK,
        output Y, V, PEND
    );

    // Requester / consumer side
    modport master (
        output EN, D, ACK,
        input  Y, V, PEND
    );
endinterface

// File: rtl/prio_encoder16.sv
// Registered 16-to-4 priority encoder: latches rising request edges into PEND and
// holds the highest pending index on Y until acknowledged or aborted by EN.
module prio_encoder16 (
    input  logic             clk,
    input  logic             rst,
    prio_encoder16_if.slave  bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  y_q, y_d;
    logic        v_q, v_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] d_q;
    logic [15:0] clr;
    logic [15:0] rise;

    // Highest set bit wins; later iterations overwrite lower indices.
    function automatic logic [3:0] hi_idx(input logic [15:0] p);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++)
            if (p[i]) idx = 4'(i);
        return idx;
    endfunction

    assign rise = bus.D & ~d_q;
    // A new edge overrides a same-cycle acknowledge clear.
    assign pend_d = (pend_q & ~clr) | rise;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        v_d     = v_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                v_d = 1'b0;
                if (bus.EN && (pend_q != 16'd0)) begin
                    y_d     = hi_idx(pend_q);
                    v_d     = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!bus.EN) begin
                    v_d     = 1'b0;
                    state_d = IDLE;
                end else if (bus.ACK) begin
                    clr[y_q] = 1'b1;
                    v_d      = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                v_d     = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= 4'd0;
            v_q     <= 1'b0;
            pend_q  <= 16'd0;
            d_q     <= 16'd0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            v_q     <= v_d;
            pend_q  <= pend_d;
            d_q     <= bus.D;
        end
    end

    assign bus.Y    = y_q;
    assign bus.V    = v_q;
    assign bus.PEND = pend_q;
endmodule

// File: tb/tb_prio_encoder16.sv
// Directed bench for prio_encoder16: each task drives a scenario and checks {V,Y,PEND}.
module tb_prio_encoder16;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    logic [20:0] exp;

    prio_encoder16_if bus();

    prio_encoder16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.EN = 1'b0; bus.D = '0; bus.ACK = 1'b0;
        tick(); tick();
        vectors++; exp = {1'b0, 4'd0, 16'h0000};
        if ({bus.V, bus.Y, bus.PEND} !== exp) begin
            miscompares++; $display("FAIL reset got %h want %h", {bus.V, bus.Y, bus.PEND}, exp);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [20:0] want [3];
        want = '{{1'b0, 4'd0, 16'h0008}, {1'b1, 4'd3, 16'h0008}, {1'b0, 4'd3, 16'h0000}};
        bus.EN = 1'b1; bus.D = 16'h0008;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({bus.V, bus.Y, bus.PEND} !== want[i]) begin
                miscompares++; $display("FAIL single[%0d] got %h want %h", i, {bus.V, bus.Y, bus.PEND}, want[i]);
            end
            bus.D = '0;
            bus.ACK = (i == 1);
        end
        bus.ACK = 1'b0;
    endtask

    task automatic test_priority();
        logic [20:0] want [10];
        want = '{{1'b0, 4'd3, 16'h8421}, {1'b1, 4'd15, 16'h8421}, {1'b0, 4'd15, 16'h0421},
                 {1'b1, 4'd10, 16'h0421}, {1'b0, 4'd10, 16'h0021}, {1'b1, 4'd5, 16'h0021},
                 {1'b0, 4'd5, 16'h0001}, {1'b1, 4'd0, 16'h0001}, {1'b0, 4'd0, 16'h0000},
                 {1'b0, 4'd0, 16'h0000}};
        bus.D = 16'h8421;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if ({bus.V, bus.Y, bus.PEND} !== want[i]) begin
                miscompares++; $display("FAIL priority[%0d] got %h want %h", i, {bus.V, bus.Y, bus.PEND}, want[i]);
            end
            // Acknowledge whenever a grant is showing; V must drop for a cycle after each.
            bus.ACK = bus.V;
        end
        bus.ACK = 1'b0;
    endtask

    task automatic test_no_preempt();
        // {ACK, D} applied before each edge, with expected {V,Y,PEND} after it
        logic [16:0] stim [14];
        logic [20:0] want [14];
        stim = '{{1'b0, 16'h0000}, {1'b0, 16'h0010}, {1'b0, 16'h0010}, {1'b0, 16'h0210},
                 {1'b0, 16'h0210}, {1'b1, 16'h0210}, {1'b0, 16'h0210}, {1'b1, 16'h0210},
                 {1'b0, 16'h0000}, {1'b0, 16'h0010}, {1'b0, 16'h0000}, {1'b1, 16'h0010},
                 {1'b0, 16'h0000}, {1'b1, 16'h0000}};
        want = '{{1'b0, 4'd0, 16'h0000}, {1'b0, 4'd0, 16'h0010}, {1'b1, 4'd4, 16'h0010},
                 {1'b1, 4'd4, 16'h0210}, {1'b1, 4'd4, 16'h0210}, {1'b0, 4'd4, 16'h0200},
                 {1'b1, 4'd9, 16'h0200}, {1'b0, 4'd9, 16'h0000}, {1'b0, 4'd9, 16'h0000},
                 {1'b0, 4'd9, 16'h0010}, {1'b1, 4'd4, 16'h0010}, {1'b0, 4'd4, 16'h0010},
                 {1'b1, 4'd4, 16'h0010}, {1'b0, 4'd4, 16'h0000}};
        for (int i = 0; i < 14; i++) begin
            {bus.ACK, bus.D} = stim[i];
            tick();
            vectors++;
            if ({bus.V, bus.Y, bus.PEND} !== want[i]) begin
                miscompares++; $display("FAIL no_preempt[%0d] got %h want %h", i, {bus.V, bus.Y, bus.PEND}, want[i]);
            end
        end
        bus.ACK = 1'b0; bus.D = '0;
    endtask

    task automatic test_level_edge();
        int grants;
        bus.ACK = 1'b1; bus.D = 16'h0004;
        grants = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.V && bus.Y == 4'd2) grants++;
        end
        vectors++;
        if (grants !== 1) begin
            miscompares++; $display("FAIL level_held grants got %0d want 1", grants);
        end
        vectors++; exp = {1'b0, 4'd2, 16'h0000};
        if ({bus.V, bus.Y, bus.PEND} !== exp) begin
            miscompares++; $display("FAIL level_end got %h want %h", {bus.V, bus.Y, bus.PEND}, exp);
        end
        bus.D = '0; tick();
        bus.D = 16'h0004;
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.V && bus.Y == 4'd2) grants++;
        end
        vectors++;
        if (grants !== 1) begin
            miscompares++; $display("FAIL level_rerise grants got %0d want 1", grants);
        end
        bus.ACK = 1'b0; bus.D = '0; tick();
    endtask

    task automatic test_enable();
        // {EN, ACK, D} applied before each edge
        logic [17:0] stim [8];
        logic [20:0] want [8];
        stim = '{{2'b00, 16'h0100}, {2'b00, 16'h0100}, {2'b10, 16'h0100}, {2'b00, 16'h0100},
                 {2'b10, 16'h0100}, {2'b01, 16'h0100}, {2'b10, 16'h0100}, {2'b11, 16'h0100}};
        want = '{{1'b0, 4'd2, 16'h0100}, {1'b0, 4'd2, 16'h0100}, {1'b1, 4'd8, 16'h0100},
                 {1'b0, 4'd8, 16'h0100}, {1'b1, 4'd8, 16'h0100}, {1'b0, 4'd8, 16'h0100},
                 {1'b1, 4'd8, 16'h0100}, {1'b0, 4'd8, 16'h0000}};
        for (int i = 0; i < 8; i++) begin
            {bus.EN, bus.ACK, bus.D} = stim[i];
            tick();
            vectors++;
            if ({bus.V, bus.Y, bus.PEND} !== want[i]) begin
                miscompares++; $display("FAIL enable[%0d] got %h want %h", i, {bus.V, bus.Y, bus.PEND}, want[i]);
            end
        end
        bus.EN = 1'b1; bus.ACK = 1'b0; bus.D = '0; tick();
    endtask

    task automatic test_mid_reset();
        // {rst, expected {V,Y,PEND}} with D held at all ones
        logic [21:0] seq [5];
        seq = '{{1'b0, 1'b0, 4'd8, 16'hFFFF}, {1'b0, 1'b1, 4'd15, 16'hFFFF},
                {1'b1, 1'b0, 4'd0, 16'h0000}, {1'b0, 1'b0, 4'd0, 16'hFFFF},
                {1'b0, 1'b1, 4'd15, 16'hFFFF}};
        bus.D = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            rst = seq[i][21];
            tick();
            vectors++;
            if ({bus.V, bus.Y, bus.PEND} !== seq[i][20:0]) begin
                miscompares++; $display("FAIL mid_reset[%0d] got %h want %h", i, {bus.V, bus.Y, bus.PEND}, seq[i][20:0]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_level_edge();
        test_enable();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
